// File: rtl/game_pkg.sv
// Shared types and default timing for the maze-game state controller.
// Holds the state encoding, default lives/frame counts and a level helper.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_DYING  = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_OVER   = 3'd5,
        ST_PAUSED = 3'd6
    } game_state_e;

    localparam int LIVES_INIT_DEF   = 3;
    localparam int READY_FRAMES_DEF = 120;
    localparam int DYING_FRAMES_DEF = 60;
    localparam int CLEAR_FRAMES_DEF = 90;

    localparam logic [3:0] LEVEL_MAX = 4'd15;

    function automatic logic [3:0] level_next(input logic [3:0] level);
        return (level == LEVEL_MAX) ? LEVEL_MAX : level + 4'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// 8-bit frame-tick counter with synchronous clear and a done-at-N compare.
// done_o fires combinationally on the tick that would make the count reach n_i.
module frame_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clear_i,
    input  logic       tick_i,
    input  logic [7:0] n_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign done_o = tick_i && (cnt_q == n_i - 8'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (tick_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow FSM: IDLE/READY/PLAY/DYING/CLEAR/OVER with lives, level and pulses.
// Optional pause support (PAUSED state, pause_key port) when GAME_PAUSE_EN is defined.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = LIVES_INIT_DEF,
    parameter int READY_FRAMES = READY_FRAMES_DEF,
    parameter int DYING_FRAMES = DYING_FRAMES_DEF,
    parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start_key,
    input  logic       collide,
    input  logic       all_eaten,
`ifdef GAME_PAUSE_EN
    input  logic       pause_key,
`endif
    output logic [2:0] state,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic       freeze,
    output logic       respawn,
    output logic       pellet_reload
);

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [7:0] READY_N    = 8'(READY_FRAMES);
    localparam logic [7:0] DYING_N    = 8'(DYING_FRAMES);
    localparam logic [7:0] CLEAR_N    = 8'(CLEAR_FRAMES);

    game_state_e state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [3:0]  level_q, level_d;
    logic        respawn_q, respawn_d;
    logic        reload_q, reload_d;

    logic        timer_tick;
    logic        timer_clear;
    logic        timer_done;
    logic [7:0]  timer_n;

`ifdef GAME_PAUSE_EN
    logic pause_q;
    logic pause_rise;
    assign pause_rise = pause_key && !pause_q;
`endif

    // Only the timed states consume frame ticks; everything else parks the counter.
    always_comb begin
        timer_n    = READY_N;
        timer_tick = 1'b0;
        unique case (state_q)
            ST_READY: begin timer_n = READY_N; timer_tick = frame_tick; end
            ST_DYING: begin timer_n = DYING_N; timer_tick = frame_tick; end
            ST_CLEAR: begin timer_n = CLEAR_N; timer_tick = frame_tick; end
            default:  ;
        endcase
    end

    // Any state change restarts the count, so a coinciding tick is dropped.
    assign timer_clear = (state_d != state_q);

    frame_timer u_frame_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (timer_clear),
        .tick_i  (timer_tick),
        .n_i     (timer_n),
        .done_o  (timer_done)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        respawn_d = 1'b0;
        reload_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_key) begin
                    state_d   = ST_READY;
                    lives_d   = LIVES_LOAD;
                    level_d   = 4'd1;
                    respawn_d = 1'b1;
                    reload_d  = 1'b1;
                end
            end
            ST_READY: begin
                if (timer_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (all_eaten) begin
                    state_d = ST_CLEAR;
                end else if (collide) begin
                    state_d = ST_DYING;
`ifdef GAME_PAUSE_EN
                end else if (pause_rise) begin
                    state_d = ST_PAUSED;
`endif
                end
            end
            ST_DYING: begin
                if (timer_done) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d   = ST_READY;
                        respawn_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (timer_done) begin
                    state_d   = ST_READY;
                    level_d   = level_next(level_q);
                    respawn_d = 1'b1;
                    reload_d  = 1'b1;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (pause_rise) state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= 3'd0;
            level_q   <= 4'd0;
            respawn_q <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            respawn_q <= respawn_d;
            reload_q  <= reload_d;
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_key;
        end
    end
`endif

    assign state         = state_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign freeze        = (state_q != ST_PLAY);
    assign respawn       = respawn_q;
    assign pellet_reload = reload_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios then random stimulus,
// every cycle compared against a rule-level game model. Pause tests need GAME_PAUSE_EN.
module tb_game_state_ctrl;

    localparam int M_IDLE = 0, M_READY = 1, M_PLAY = 2, M_DYING = 3,
                   M_CLEAR = 4, M_OVER = 5, M_PAUSED = 6;
    localparam int N_READY = 120, N_DYING = 60, N_CLEAR = 90, N_LIVES = 3;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, start_key, collide, all_eaten, pause_key;
    logic [2:0] state, lives;
    logic [3:0] level;
    logic       freeze, respawn, pellet_reload;

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Reference model: game situation expressed as plain numbers.
    int m_st, m_lives, m_level, m_ticks, m_resp, m_rel, m_pk_prev;

    always #5 Clk = ~Clk;

    game_state_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .start_key     (start_key),
        .collide       (collide),
        .all_eaten     (all_eaten),
`ifdef GAME_PAUSE_EN
        .pause_key     (pause_key),
`endif
        .state         (state),
        .lives         (lives),
        .level         (level),
        .freeze        (freeze),
        .respawn       (respawn),
        .pellet_reload (pellet_reload)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void game_start();
        m_st = M_READY; m_lives = N_LIVES; m_level = 1; m_ticks = 0;
        m_resp = 1; m_rel = 1;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_step();
        int pedge;
        pedge = 0;
`ifdef GAME_PAUSE_EN
        pedge = (pause_key && !m_pk_prev) ? 1 : 0;
`endif
        m_resp = 0;
        m_rel  = 0;
        if (Reset) begin
            m_st = M_IDLE; m_lives = 0; m_level = 0; m_ticks = 0; m_pk_prev = 0;
            return;
        end
        m_pk_prev = pause_key ? 1 : 0;
        case (m_st)
            M_IDLE, M_OVER: if (start_key) game_start();
            M_READY: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == N_READY) begin m_st = M_PLAY; m_ticks = 0; end
            end
            M_PLAY: begin
                if (all_eaten)    m_st = M_CLEAR;
                else if (collide) m_st = M_DYING;
                else if (pedge)   m_st = M_PAUSED;
                m_ticks = 0;
            end
            M_DYING: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == N_DYING) begin
                    m_ticks = 0;
                    if (m_lives == 1) begin
                        m_st = M_OVER; m_lives = 0;
                    end else begin
                        m_st = M_READY; m_lives = m_lives - 1; m_resp = 1;
                    end
                end
            end
            M_CLEAR: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == N_CLEAR) begin
                    m_ticks = 0; m_st = M_READY;
                    m_level = (m_level >= 15) ? 15 : m_level + 1;
                    m_resp = 1; m_rel = 1;
                end
            end
            M_PAUSED: if (pedge) m_st = M_PLAY;
            default: m_st = M_IDLE;
        endcase
    endfunction

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        chk("state",   {5'd0, state},          8'(m_st));
        chk("lives",   {5'd0, lives},          8'(m_lives));
        chk("level",   {4'd0, level},          8'(m_level));
        chk("freeze",  {7'd0, freeze},         (m_st == M_PLAY) ? 8'd0 : 8'd1);
        chk("respawn", {7'd0, respawn},        8'(m_resp));
        chk("reload",  {7'd0, pellet_reload},  8'(m_rel));
    endtask

    // n frame ticks, each preceded by an idle cycle; ends right after the last tick edge.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b0; cycle();
            frame_tick = 1'b1; cycle();
        end
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start_key = 1'b1; cycle(); start_key = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; start_key = 1'b0;
        collide = 1'b0; all_eaten = 1'b0; pause_key = 1'b0;
        m_st = M_IDLE; m_lives = 0; m_level = 0; m_ticks = 0;
        m_resp = 0; m_rel = 0; m_pk_prev = 0;
        @(negedge Clk);
        cycle(); cycle();
        Reset = 1'b0;
        cycle();
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_freeze", {7'd0, freeze}, 8'd1);

        // Start with a coinciding tick: that tick must not count toward READY.
        frame_tick = 1'b1; pulse_start(); frame_tick = 1'b0;
        chk("start_lives", {5'd0, lives}, 8'd3);
        chk("start_respawn", {7'd0, respawn}, 8'd1);
        chk("start_reload", {7'd0, pellet_reload}, 8'd1);
        run_ticks(119);
        chk("ready_119", {5'd0, state}, 8'd1);
        run_ticks(1);
        chk("ready_done", {5'd0, state}, 8'd2);
        chk("play_freeze", {7'd0, freeze}, 8'd0);

        // Lose all three lives.
        for (int k = 0; k < 3; k++) begin
            collide = 1'b1; cycle(); collide = 1'b0;
            chk("dying", {5'd0, state}, 8'd3);
            run_ticks(60);
            chk("dying_lives", {5'd0, lives}, 8'(2 - k));
            if (k < 2) begin
                chk("dying_respawn", {7'd0, respawn}, 8'd1);
                run_ticks(120);
            end
        end
        chk("over_state", {5'd0, state}, 8'd5);

        // Restart from OVER, then clear with collide and all_eaten together.
        pulse_start();
        chk("restart_lives", {5'd0, lives}, 8'd3);
        run_ticks(120);
        collide = 1'b1; all_eaten = 1'b1; cycle(); collide = 1'b0; all_eaten = 1'b0;
        chk("clear_prio", {5'd0, state}, 8'd4);
        run_ticks(90);
        chk("clear_level", {4'd0, level}, 8'd2);
        chk("clear_lives", {5'd0, lives}, 8'd3);
        chk("clear_reload", {7'd0, pellet_reload}, 8'd1);

        // Climb to level 15 and clear once more: level saturates.
        for (int k = 0; k < 14; k++) begin
            run_ticks(120);
            all_eaten = 1'b1; cycle(); all_eaten = 1'b0;
            run_ticks(90);
        end
        chk("level_sat", {4'd0, level}, 8'd15);

        // Reset in the middle of DYING; collide afterwards is ignored.
        run_ticks(120);
        collide = 1'b1; cycle();
        run_ticks(30);
        Reset = 1'b1; collide = 1'b1; cycle(); Reset = 1'b0;
        chk("mid_rst_state", {5'd0, state}, 8'd0);
        chk("mid_rst_lives", {5'd0, lives}, 8'd0);
        run_ticks(20);
        collide = 1'b0;
        chk("idle_collide", {5'd0, state}, 8'd0);
        pulse_start();
        run_ticks(119);
        chk("cnt_cleared", {5'd0, state}, 8'd1);
        run_ticks(1);
        chk("cnt_cleared_play", {5'd0, state}, 8'd2);

`ifdef GAME_PAUSE_EN
        pause_key = 1'b1; cycle();
        chk("paused", {5'd0, state}, 8'd6);
        collide = 1'b1;
        run_ticks(50);
        collide = 1'b0;
        chk("paused_hold", {5'd0, state}, 8'd6);
        pause_key = 1'b0; cycle();
        pause_key = 1'b1; cycle();
        chk("unpaused", {5'd0, state}, 8'd2);
        pause_key = 1'b0; cycle();
`endif

        // Random play against the model.
        for (int i = 0; i < 12000; i++) begin
            Reset      = ($urandom_range(0, 1499) == 0);
            frame_tick = ($urandom_range(0, 1) == 1);
            start_key  = ($urandom_range(0, 15) == 0);
            collide    = ($urandom_range(0, 9) == 0);
            all_eaten  = ($urandom_range(0, 24) == 0);
            pause_key  = ($urandom_range(0, 7) == 0) ? ~pause_key : pause_key;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start; legal range 1..7.
REQ-002 Parameter READY_FRAMES, default 120: frame ticks spent in READY before play.
REQ-003 Parameter DYING_FRAMES, default 60: frame ticks spent in DYING (death animation).
REQ-004 Parameter CLEAR_FRAMES, default 90: frame ticks spent in CLEAR (level-complete flash).
REQ-005 Clk  in  1  single system clock; every flop is clocked on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-007 frame_tick  in  1  one-Clk pulse per video frame; all timers advance only on it.
REQ-008 start_key  in  1  level; start or restart request.
REQ-009 collide  in  1  level; ghost/pac overlap from the collision detector.
REQ-010 all_eaten  in  1  level; every pellet has been consumed.
REQ-011 state  out  3  encoded FSM state (IDLE=0, READY=1, PLAY=2, DYING=3, CLEAR=4, OVER=5, PAUSED=6).
REQ-012 lives  out  3  remaining lives.
REQ-013 level  out  4  current level number, saturating at 15.
REQ-014 freeze  out  1  high in every state except PLAY; movers hold position.
REQ-015 respawn  out  1  one-Clk pulse; actors return to start positions.
REQ-016 pellet_reload  out  1  one-Clk pulse; pellet map refills.

Function
REQ-017 IDLE: on start_key=1 -> READY; lives<=LIVES_INIT, level<=1, respawn=1 and pellet_reload=1 in the same cycle.
REQ-018 READY: frame counter increments on each frame_tick; on tick number READY_FRAMES -> PLAY, counter cleared.
REQ-019 PLAY: all_eaten=1 -> CLEAR; else collide=1 -> DYING; all_eaten has priority when both are high in the same cycle.
REQ-020 DYING: after DYING_FRAMES ticks, lives decrements by 1; if the pre-decrement value was 1 -> OVER, else -> READY with a respawn pulse.
REQ-021 CLEAR: after CLEAR_FRAMES ticks -> READY; level increments (saturating at 15); respawn and pellet_reload pulse in that cycle; lives unchanged.
REQ-022 OVER: lives=0; start_key=1 behaves exactly as in IDLE (REQ-017).
REQ-023 collide and all_eaten are ignored outside PLAY; start_key is ignored outside IDLE/OVER.
REQ-024 Frame counter is 8 bits wide, clears on every state change, and never wraps within a state (all *_FRAMES values <=255).
REQ-025 The respawn and pellet_reload outputs are registered; each is high for exactly one Clk per triggering transition.
REQ-026 A frame_tick coinciding with a state transition counts toward neither the old state nor the new one.

Reset
REQ-027 Reset=1 -> state=IDLE, lives=0, level=0, counter=0, freeze=1, respawn=0, pellet_reload=0 on the next edge of Clk, from any state (including mid-DYING or mid-CLEAR).
REQ-028 Reset has priority over all other inputs in the same cycle.

Configuration
REQ-029 Macro GAME_PAUSE_EN defined: adds input pause_key (1 bit, level); a rising edge of pause_key in PLAY -> PAUSED; a rising edge in PAUSED -> PLAY; frame counter and lives are held while in PAUSED; collide is ignored while in PAUSED.
REQ-030 GAME_PAUSE_EN undefined: no pause_key port and no PAUSED state; encoding 6 is unreachable.

Structure
REQ-031 Shared package game_pkg holds the state enum typedef, the state encodings, and the LIVES_INIT/READY_FRAMES/DYING_FRAMES/CLEAR_FRAMES defaults.
REQ-032 One sub-module, frame_timer (8-bit tick counter with clear and a done-at-N compare), is instantiated once.

Verification
REQ-033 Reset, start_key=1 for 1 cycle -> state=READY, lives=3, level=1, respawn and pellet_reload each 1 cycle; after 120 ticks -> PLAY, freeze=0.
REQ-034 In PLAY, collide=1 -> DYING; after 60 ticks lives=2, state=READY, respawn pulse; repeat twice more -> OVER, lives=0.
REQ-035 In PLAY, collide=1 and all_eaten=1 in the same cycle -> CLEAR; after 90 ticks level=2, lives unchanged, respawn and pellet_reload pulse.
REQ-036 Reset asserted at DYING tick 30 -> next cycle state=IDLE, lives=0, counter=0; collide held high afterwards has no effect.
REQ-037 GAME_PAUSE_EN defined: pause_key edge in PLAY -> PAUSED, freeze=1; 50 ticks plus collide=1 -> no change; second pause_key edge -> PLAY.
REQ-038 Level at 15 followed by a clear -> level stays 15.
